rr_mux_n: RTL and testbench
===========================

RR_MUX_N -- requirements
Module: rr_mux_n

Interface
REQ-001 Parameter N_CH, default 16: number of input channels, range 2..64.
REQ-002 Parameter DW, default 32: data width per channel, range 1..256.
REQ-003 Derived constant SW = clog2(N_CH): width of the channel index.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_data  in  N_CH*DW  flattened channel data; channel i occupies bits [i*DW +: DW].
REQ-007 in_valid  in  N_CH  per-channel valid.
REQ-008 in_ready  out  N_CH  per-channel ready; one-hot or zero.
REQ-009 mode  in  1  0 = fixed select, 1 = round-robin.
REQ-010 sel  in  SW  channel index used when mode = 0.
REQ-011 out_data  out  DW  registered selected data.
REQ-012 out_ch  out  SW  index of the channel that supplied out_data.
REQ-013 out_valid  out  1  output register holds data.
REQ-014 out_ready  in  1  downstream accept.

Function
REQ-015 The block shall contain a one-entry output register; a transfer occurs on a channel when in_valid[i] && in_ready[i], and on the output when out_valid && out_ready.
REQ-016 load_en shall equal !out_valid || out_ready, so a drain and a load can occur in the same cycle, giving full throughput.
REQ-017 In mode 0, grant shall be sel when in_valid[sel] is high and sel < N_CH; otherwise there is no grant.
REQ-018 In mode 1, grant shall be the first channel with in_valid high, searching upward from last_grant+1 modulo N_CH.
REQ-019 in_ready[grant] shall equal load_en; all other in_ready bits shall be 0; in_ready shall be combinational on in_valid, mode, sel and the state.
REQ-020 On a load, out_data <= the granted channel's data, out_ch <= grant, out_valid <= 1, and last_grant <= grant (last_grant updates in both modes).
REQ-021 On a drain with no load, out_valid <= 0; out_data and out_ch shall hold their values.
REQ-022 While out_valid && !out_ready, out_data and out_ch shall be stable and all in_ready bits shall be 0.
REQ-023 Latency from the input transfer to out_valid shall be 1 cycle.
REQ-024 Changes to mode or sel shall affect only the next grant; a held output is unaffected.
REQ-025 Round-robin wrap: after a grant to channel N_CH-1, the search shall start at channel 0.

Reset
REQ-026 While rst is high: out_valid=0, out_data=0, out_ch=0, in_ready=0, last_grant=N_CH-1 (so the first round-robin search starts at 0).
REQ-027 Reset asserted mid-transfer shall discard the held output with no drain; the first load may occur in the cycle after rst deasserts.

Configuration
REQ-028 Macro RR_MUX_CNT_EN defined: the block shall add an output port out_cnt [15:0], reset to 0, incremented on each output transfer and wrapping from 65535 to 0.
REQ-029 Macro RR_MUX_CNT_EN undefined: the out_cnt port and its counter shall not exist; all other behaviour is identical.

Structure
REQ-030 Shared package mux_pkg shall hold the clog2 function and the mode encodings MODE_FIXED=0 and MODE_RR=1.
REQ-031 Sub-module rr_arbiter shall be instantiated: N_CH request bits plus a last-grant pointer in, a one-hot grant plus a grant-valid flag out, purely combinational rotate-priority.
REQ-032 The output register, load/drain control and optional counter shall reside in rr_mux_n.

Verification
REQ-033 Mode 0, sel=5, in_valid=16'h0020, out_ready=1 -> in_ready=16'h0020; next cycle out_data=ch5 data, out_ch=5, out_valid=1.
REQ-034 Mode 1, in_valid=16'hFFFF held, out_ready=1 for 17 cycles after reset -> out_ch sequence 0,1,...,15,0.
REQ-035 Mode 1, in_valid=16'h8001, last_grant=15 -> grants 0,15,0,15 on consecutive cycles.
REQ-036 out_valid=1 with out_ready=0 for 4 cycles and inputs changing -> out_data and out_ch constant, in_ready=0; out_ready=1 -> drain and reload in the same cycle.
REQ-037 Mode 0, sel=3, in_valid[3]=0 while other channels are valid -> in_ready=0 and out_valid falls after the drain.
REQ-038 rst pulsed while out_valid=1 -> next cycle all outputs are 0; with RR_MUX_CNT_EN, 65536 transfers return out_cnt to 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin channel mux: mode encodings and
// a constant-foldable clog2 used to size channel indices.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, usable in parameter expressions
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter. The search starts one past the
// last granted channel and wraps modulo N_CH; the result is one-hot.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 16,
  parameter int SW   = clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [SW-1:0]   last_i,
  output logic [N_CH-1:0] gnt_o,
  output logic            gnt_vld_o
);

  int idx;

  // First requester found walking upward from last_i+1 wins
  always_comb begin
    gnt_o     = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last_i) + k) % N_CH;
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_vld_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel mux with fixed-select or round-robin arbitration feeding a
// one-entry output register. Drain and load may happen in the same cycle.
// Optional feature: define RR_MUX_CNT_EN to add the out_cnt transfer counter.
module rr_mux_n
  import mux_pkg::*;
#(
  parameter  int N_CH = 16,
  parameter  int DW   = 32,
  localparam int SW   = clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_valid,
  output logic [N_CH-1:0]    in_ready,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  output logic [DW-1:0]      out_data,
  output logic [SW-1:0]      out_ch,
  output logic               out_valid,
`ifdef RR_MUX_CNT_EN
  output logic [15:0]        out_cnt,
`endif
  input  logic               out_ready
);

  logic [DW-1:0]   out_data_q, out_data_d;
  logic [SW-1:0]   out_ch_q, out_ch_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   last_grant_q, last_grant_d;

  logic [N_CH-1:0] rr_gnt;
  logic            rr_vld;
  logic [N_CH-1:0] gnt_oh;
  logic [SW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic            load_en;
  logic            load;

  rr_arbiter #(.N_CH(N_CH), .SW(SW)) u_arb (
    .req_i     (in_valid),
    .last_i    (last_grant_q),
    .gnt_o     (rr_gnt),
    .gnt_vld_o (rr_vld)
  );

  // Pick the grant source by mode; out-of-range sel never grants
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (mode == MODE_RR) begin
      gnt_oh  = rr_gnt;
      gnt_vld = rr_vld;
      for (int i = 0; i < N_CH; i++) begin
        if (rr_gnt[i]) gnt_idx = SW'(i);
      end
    end else if (int'(sel) < N_CH) begin
      gnt_vld      = in_valid[sel];
      gnt_oh[sel]  = in_valid[sel];
      gnt_idx      = sel;
    end
  end

  assign load_en  = !out_valid_q || out_ready;
  assign load     = load_en && gnt_vld && !rst;
  assign in_ready = load ? gnt_oh : '0;

  // Next-state for the output register: load wins, else drain clears valid
  always_comb begin
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_data_d   = in_data[int'(gnt_idx)*DW +: DW];
      out_ch_d     = gnt_idx;
      out_valid_d  = 1'b1;
      last_grant_d = gnt_idx;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // Output register and arbitration pointer; reset discards any held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= SW'(N_CH - 1);
    end else begin
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef RR_MUX_CNT_EN
  logic [15:0] cnt_q;

  // Counts output transfers, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst)                           cnt_q <= '0;
    else if (out_valid_q && out_ready) cnt_q <= cnt_q + 16'd1;
  end

  assign out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed bench for rr_mux_n at default parameters (16 channels x 32 bits).
module tb_rr_mux_n;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] in_data;
  logic [15:0]  in_valid;
  logic [15:0]  in_ready;
  logic         mode;
  logic [3:0]   sel;
  logic [31:0]  out_data;
  logic [3:0]   out_ch;
  logic         out_valid;
  logic         out_ready;
`ifdef RR_MUX_CNT_EN
  logic [15:0]  out_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rr_mux_n dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
`ifdef RR_MUX_CNT_EN
    .out_cnt   (out_cnt),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] d(input logic [15:0] salt, input int ch);
    return {salt, 8'h00, 8'(ch)};
  endfunction

  task automatic set_data(input logic [15:0] salt);
    for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = d(salt, i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 4'd0; in_valid = 16'hFFFF; out_ready = 1'b1;
    set_data(16'hAAAA);
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL rst_data got %h want 0", out_data); end
    n_cmp++; if (out_ch !== 4'd0) begin n_bad++; $display("FAIL rst_ch got %0d want 0", out_ch); end
    n_cmp++; if (in_ready !== 16'h0) begin n_bad++; $display("FAIL rst_in_ready got %h want 0", in_ready); end
  endtask

  task automatic test_fixed();
    rst = 1'b0; mode = 1'b0; sel = 4'd5; in_valid = 16'h0020; out_ready = 1'b1;
    set_data(16'h1111);
    #1;
    n_cmp++; if (in_ready !== 16'h0020) begin n_bad++; $display("FAIL fixed_in_ready got %h want 0020", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fixed_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_ch !== 4'd5) begin n_bad++; $display("FAIL fixed_ch got %0d want 5", out_ch); end
    n_cmp++; if (out_data !== d(16'h1111, 5)) begin n_bad++; $display("FAIL fixed_data got %h want %h", out_data, d(16'h1111, 5)); end
  endtask

  task automatic test_rr_seq();
    logic [15:0] exp_rdy;
    do_reset();
    mode = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
    set_data(16'h2020);
    for (int i = 0; i < 17; i++) begin
      exp_rdy = 16'h0001 << (i % 16);
      #1;
      n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_seq_rdy[%0d] got %h want %h", i, in_ready, exp_rdy); end
      tick();
      n_cmp++; if (out_ch !== 4'(i % 16) || out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_seq_ch[%0d] got %0d/%0b want %0d/1", i, out_ch, out_valid, i % 16); end
      n_cmp++; if (out_data !== d(16'h2020, i % 16)) begin n_bad++; $display("FAIL rr_seq_data[%0d] got %h want %h", i, out_data, d(16'h2020, i % 16)); end
    end
  endtask

  task automatic test_rr_pair();
    logic [3:0] exp_ch;
    do_reset();
    mode = 1'b1; in_valid = 16'h8001; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_ch = (i % 2 == 1) ? 4'd15 : 4'd0;
      tick();
      n_cmp++; if (out_ch !== exp_ch || out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_pair[%0d] got %0d/%0b want %0d/1", i, out_ch, out_valid, exp_ch); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    mode = 1'b0; sel = 4'd2; in_valid = 16'h0004; out_ready = 1'b0;
    set_data(16'h2222);
    tick();
    n_cmp++; if (out_ch !== 4'd2 || out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_load got %0d/%0b want 2/1", out_ch, out_valid); end
    for (int k = 0; k < 4; k++) begin
      mode = k[0]; sel = 4'(k + 8); in_valid = 16'hFFFF >> k;
      set_data(16'h5000 + 16'(k));
      #1;
      n_cmp++; if (in_ready !== 16'h0) begin n_bad++; $display("FAIL hold_rdy[%0d] got %h want 0", k, in_ready); end
      tick();
      n_cmp++; if (out_ch !== 4'd2 || out_data !== d(16'h2222, 2) || out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_out[%0d] got %0d/%h/%0b want 2/%h/1", k, out_ch, out_data, out_valid, d(16'h2222, 2)); end
    end
    // last grant was 2, so round-robin search starts at 3 and finds 4
    out_ready = 1'b1; mode = 1'b1; in_valid = 16'h0010;
    set_data(16'h3333);
    #1;
    n_cmp++; if (in_ready !== 16'h0010) begin n_bad++; $display("FAIL reload_rdy got %h want 0010", in_ready); end
    tick();
    n_cmp++; if (out_ch !== 4'd4 || out_data !== d(16'h3333, 4) || out_valid !== 1'b1) begin n_bad++; $display("FAIL reload_out got %0d/%h/%0b want 4/%h/1", out_ch, out_data, out_valid, d(16'h3333, 4)); end
  endtask

  task automatic test_fixed_miss();
    mode = 1'b0; sel = 4'd3; in_valid = 16'hFFF7; out_ready = 1'b1;
    set_data(16'h4444);
    #1;
    n_cmp++; if (in_ready !== 16'h0) begin n_bad++; $display("FAIL miss_rdy got %h want 0", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL miss_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_ch !== 4'd4 || out_data !== d(16'h3333, 4)) begin n_bad++; $display("FAIL miss_hold got %0d/%h want 4/%h", out_ch, out_data, d(16'h3333, 4)); end
  endtask

  task automatic test_rst_mid();
    mode = 1'b0; sel = 4'd7; in_valid = 16'h0080; out_ready = 1'b0;
    set_data(16'h7777);
    tick();
    n_cmp++; if (out_ch !== 4'd7 || out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_load got %0d/%0b want 7/1", out_ch, out_valid); end
    rst = 1'b1; mode = 1'b1; in_valid = 16'hFFFF;
    #1;
    n_cmp++; if (in_ready !== 16'h0) begin n_bad++; $display("FAIL mid_rst_rdy got %h want 0", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_ch !== 4'd0) begin n_bad++; $display("FAIL mid_rst_out got %0b/%h/%0d want 0/0/0", out_valid, out_data, out_ch); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 16'h0001) begin n_bad++; $display("FAIL post_rst_rdy got %h want 0001", in_ready); end
    tick();
    n_cmp++; if (out_ch !== 4'd0 || out_valid !== 1'b1 || out_data !== d(16'h7777, 0)) begin n_bad++; $display("FAIL post_rst_out got %0d/%0b/%h want 0/1/%h", out_ch, out_valid, out_data, d(16'h7777, 0)); end
  endtask

`ifdef RR_MUX_CNT_EN
  task automatic test_cnt();
    do_reset();
    mode = 1'b1; in_valid = 16'hFFFF; out_ready = 1'b1;
    n_cmp++; if (out_cnt !== 16'd0) begin n_bad++; $display("FAIL cnt_rst got %0d want 0", out_cnt); end
    tick();
    tick();
    n_cmp++; if (out_cnt !== 16'd1) begin n_bad++; $display("FAIL cnt_one got %0d want 1", out_cnt); end
    for (int i = 0; i < 65535; i++) tick();
    n_cmp++; if (out_cnt !== 16'd0) begin n_bad++; $display("FAIL cnt_wrap got %0d want 0", out_cnt); end
  endtask
`endif

  initial begin
    in_data = '0;
    test_reset();
    test_fixed();
    test_rr_seq();
    test_rr_pair();
    test_hold();
    test_fixed_miss();
    test_rst_mid();
`ifdef RR_MUX_CNT_EN
    test_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
